scroll_frame_gen: RTL

Upstream frame source for the 8x8 LED matrix scan driver. It holds a short message of glyph codes and renders a horizontally scrolling 64-bit frame window over the concatenated glyphs, advancing one column per step tick. It presents each new frame with a one-cycle strobe. The scan driver latches that frame and multiplexes it onto row/col_r/col_g.

---
 rtl/scroll_frame_gen.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/scroll_frame_gen.sv
// Scrolling 8x8 frame source: renders a 64-bit window over a glyph message, one column per step.
// Optional macro BLANK_GAP_EN appends a blank pseudo-glyph after the last message entry.
module scroll_frame_gen #(
   parameter int STEP_TICKS = 1000,
   parameter int MSG_DEPTH  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic [3:0]  wr_addr,
   input  logic [5:0]  wr_code,
   input  logic [4:0]  msg_len,
   input  logic        run,
   output logic [63:0] frame,
   output logic        frame_stb,
   output logic        wrap
);

   localparam int CW = $clog2(STEP_TICKS);
   localparam logic [CW-1:0] LAST_CNT = CW'(STEP_TICKS - 1);

   typedef enum logic {S_HOLD, S_SCROLL} state_t;

   state_t        state, state_d;
   logic          count_en;
   logic [CW-1:0] cnt;
   logic [4:0]    idx;
   logic [2:0]    off;
   logic [5:0]    mem [MSG_DEPTH];

   logic          step, blank, stale;
   logic [4:0]    seq_last, cur_idx, nxt_idx;
   logic [2:0]    cur_off;
   logic [63:0]   g_cur, g_nxt, frame_d;
   logic [15:0]   pair, shifted;

   function automatic logic [63:0] font(input logic [5:0] code);
      case (code)
         6'd0:  font = 64'h007CC6CED6E67C00;
         6'd1:  font = 64'h0018381818187E00;
         6'd2:  font = 64'h007CC60C3060FE00;
         6'd3:  font = 64'h007CC61C06C67C00;
         6'd4:  font = 64'h001C3C6CFE0C0C00;
         6'd5:  font = 64'h00FEC0FC06C67C00;
         6'd6:  font = 64'h003C60FCC6C67C00;
         6'd7:  font = 64'h00FE060C18303000;
         6'd8:  font = 64'h007CC67CC6C67C00;
         6'd9:  font = 64'h007CC6C67E067C00;
         6'd10: font = 64'h00386CC6FEC6C600;
         6'd11: font = 64'h00FEC2FCC2C2FC00;
         6'd12: font = 64'h007CC6C0C0C67C00;
         6'd13: font = 64'h00FCC6C6C6C6FC00;
         6'd14: font = 64'h00FEC0FCC0C0FE00;
         6'd15: font = 64'h00FEC0FCC0C0C000;
         6'd16: font = 64'h007CC0CEC6C67E00;
         6'd17: font = 64'h00C6C6FEC6C6C600;
         6'd18: font = 64'h007E181818187E00;
         6'd19: font = 64'h007E181818181800;
         6'd20: font = 64'h00C6C6C6C6C67C00;
         6'd21: font = 64'h00C6CCF8F8CCC600;
         6'd22: font = 64'h00C0C0C0C0C0FE00;
         6'd23: font = 64'h00C6EEFED6C6C600;
         6'd24: font = 64'h00C6E6F6DECEC600;
         6'd25: font = 64'h007CC6C6C6C67C00;
         6'd26: font = 64'h00FCC6C6FCC0C000;
         6'd27: font = 64'h007CC6C6D6CC7600;
         6'd28: font = 64'h00FCC6C6FCCCC600;
         6'd29: font = 64'h007CC07C06067C00;
         6'd30: font = 64'h00C6C6C6C66C3800;
         6'd31: font = 64'h00C6C6D6FEEEC600;
         6'd32: font = 64'h00C66C38386CC600;
         6'd33: font = 64'h0066663C18181800;
         6'd34: font = 64'h00FE0C183060FE00;
         6'd35: font = 64'h00FE060C3060FE00;
         default: font = 64'h0;
      endcase
   endfunction

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_code;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_HOLD;
      else     state <= state_d;
   end

   always_comb begin
      state_d = state;
      case (state)
         S_HOLD:   if (run)  state_d = S_SCROLL;
         S_SCROLL: if (!run) state_d = S_HOLD;
         default:  state_d = S_HOLD;
      endcase
   end

   // Counting follows the run level in the same cycle; there is no start-up load.
   always_comb begin
      count_en = (state_d == S_SCROLL);
   end

   always_comb begin
      step  = count_en && (cnt == LAST_CNT);
      blank = (msg_len == 5'd0) || (msg_len > 5'd16);
`ifdef BLANK_GAP_EN
      seq_last = msg_len;
`else
      seq_last = msg_len - 5'd1;
`endif
      // A shortened message restarts rendering from entry 0.
      stale   = (idx > seq_last);
      cur_idx = stale ? 5'd0 : idx;
      cur_off = stale ? 3'd0 : off;
      nxt_idx = (cur_idx == seq_last) ? 5'd0 : cur_idx + 5'd1;
`ifdef BLANK_GAP_EN
      g_cur = (cur_idx == msg_len) ? 64'h0 : font(mem[cur_idx[3:0]]);
      g_nxt = (nxt_idx == msg_len) ? 64'h0 : font(mem[nxt_idx[3:0]]);
`else
      g_cur = font(mem[cur_idx[3:0]]);
      g_nxt = font(mem[nxt_idx[3:0]]);
`endif
   end

   always_comb begin
      frame_d = '0;
      pair    = '0;
      shifted = '0;
      for (int r = 0; r < 8; r++) begin
         pair    = {g_cur[63-8*r -: 8], g_nxt[63-8*r -: 8]};
         shifted = pair << cur_off;
         frame_d[63-8*r -: 8] = shifted[15:8];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         idx       <= '0;
         off       <= '0;
         frame     <= '0;
         frame_stb <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         frame_stb <= 1'b0;
         wrap      <= 1'b0;
         if (count_en) cnt <= step ? '0 : cnt + CW'(1);
         if (step) begin
            frame_stb <= 1'b1;
            if (blank) begin
               frame <= '0;
               idx   <= '0;
               off   <= '0;
            end else begin
               frame <= frame_d;
               if (cur_off == 3'd7) begin
                  off  <= 3'd0;
                  idx  <= nxt_idx;
                  wrap <= (cur_idx == seq_last);
               end else begin
                  off <= cur_off + 3'd1;
                  idx <= cur_idx;
               end
            end
         end
      end
   end

endmodule
